// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 20;
  localparam int DATA_BITS            = 8;

  typedef enum logic [2:0] {
    s_idle      = 3'd0,
    s_start_bit = 3'd1,
    s_data_bits = 3'd2,
    s_stop_bit  = 3'd3,
    s_cleanup   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit qualification at half bit, mid-bit data sampling,
// one-cycle done / frame-error strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] out_Byte,
  output logic       r_done,
  output logic       r_frame_err,
  output logic       busy
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0] HALF_CNT = 8'(HALF_BIT);
  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  uart_state_e r_state, w_state_nx;
  logic [7:0]  r_count, w_count_nx;
  logic [2:0]  r_index, w_index_nx;
  logic [7:0]  r_shift, w_shift_nx;
  logic [7:0]  w_byte_nx;
  logic        w_done_nx, w_err_nx;
  logic        w_rx;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (serial_in),
    .o_q   (w_rx)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= s_idle;
      r_count     <= '0;
      r_index     <= '0;
      r_shift     <= '0;
      out_Byte    <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_count     <= w_count_nx;
      r_index     <= w_index_nx;
      r_shift     <= w_shift_nx;
      out_Byte    <= w_byte_nx;
      r_done      <= w_done_nx;
      r_frame_err <= w_err_nx;
    end
  end

  // Strobes default low every cycle, so each pulse lasts exactly one clock.
  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_index_nx = r_index;
    w_shift_nx = r_shift;
    w_byte_nx  = out_Byte;
    w_done_nx  = 1'b0;
    w_err_nx   = 1'b0;
    unique case (r_state)
      s_idle: begin
        w_count_nx = '0;
        w_index_nx = '0;
        if (!w_rx) w_state_nx = s_start_bit;
      end
      s_start_bit: begin
        if (r_count == HALF_CNT) begin
          w_count_nx = '0;
          w_state_nx = w_rx ? s_idle : s_data_bits;
        end else begin
          w_count_nx = r_count + 8'd1;
        end
      end
      s_data_bits: begin
        if (r_count == LAST_CNT) begin
          w_count_nx          = '0;
          w_shift_nx[r_index] = w_rx;
          if (r_index == LAST_IDX) begin
            w_index_nx = '0;
            w_state_nx = s_stop_bit;
          end else begin
            w_index_nx = r_index + 3'd1;
          end
        end else begin
          w_count_nx = r_count + 8'd1;
        end
      end
      s_stop_bit: begin
        if (r_count == LAST_CNT) begin
          w_count_nx = '0;
          if (w_rx) begin
            w_byte_nx = r_shift;
            w_done_nx = 1'b1;
          end else begin
            w_err_nx = 1'b1;
          end
          w_state_nx = s_cleanup;
        end else begin
          w_count_nx = r_count + 8'd1;
        end
      end
      s_cleanup: begin
        // A held-low break line parks here, yielding a single error pulse.
        if (w_rx) w_state_nx = s_idle;
      end
      default: w_state_nx = s_idle;
    endcase
  end

  assign busy = (r_state != s_idle);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized loopback
// against a queue-based model of sent bytes.
module tb_uart_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b1;
  logic [7:0] out_Byte;
  logic       r_done;
  logic       r_frame_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int t_fall = 0;
  logic prev_done = 1'b0;
  logic [7:0] got[$];
  int done_t[$];

  uart_rx #(.CLKS_PER_BIT(20)) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_in   (serial_in),
    .out_Byte    (out_Byte),
    .r_done      (r_done),
    .r_frame_err (r_frame_err),
    .busy        (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: records received bytes and pulse times, checks exclusivity.
  always @(negedge clock) begin
    if (r_done === 1'b1) begin
      done_cnt++;
      got.push_back(out_Byte);
      done_t.push_back(cyc);
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      chk("done_err_exclusive", {31'd0, r_frame_err}, 32'd0);
    end
    if (r_frame_err === 1'b1) err_cnt++;
    prev_done = (r_done === 1'b1);
  end

  // Line driver: caller is positioned 1 time unit after a rising edge.
  task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t_fall = cyc;
    for (int i = 0; i < 10; i++) begin
      serial_in = bits[i];
      repeat (cpb) @(posedge clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 600 && done_cnt < n; i++) @(negedge clock);
  endtask

  initial begin
    int base, ebase, busy_cycles, fall0;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int cpbs[2];
    cpbs[0] = 19;
    cpbs[1] = 21;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_out_byte", {24'd0, out_Byte}, 32'd0);
    chk("rst_done", {31'd0, r_done}, 32'd0);
    chk("rst_err", {31'd0, r_frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle(5);

    // Single frame 0xA5: latency and value
    done_t.delete();
    send_frame(8'hA5, 20, 1'b1);
    fall0 = t_fall;
    wait_done(1);
    chk("a5_done_cnt", done_cnt, 1);
    chk("a5_byte", {24'd0, out_Byte}, 32'hA5);
    if (done_t.size() > 0) begin
      chk("a5_latency_ok", {31'd0, (done_t[0] - fall0 >= 192) && (done_t[0] - fall0 <= 194)}, 32'd1);
    end
    idle(5);
    @(negedge clock);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    chk("a5_err_cnt", err_cnt, 0);
    @(posedge clock); #1;

    // Back-to-back 0x00 then 0xFF
    done_t.delete();
    got.delete();
    send_frame(8'h00, 20, 1'b1);
    send_frame(8'hFF, 20, 1'b1);
    wait_done(3);
    chk("b2b_done_cnt", done_cnt, 3);
    if (got.size() == 2 && done_t.size() == 2) begin
      chk("b2b_byte0", {24'd0, got[0]}, 32'h00);
      chk("b2b_byte1", {24'd0, got[1]}, 32'hFF);
      chk("b2b_spacing", done_t[1] - done_t[0], 200);
    end else begin
      chk("b2b_capture_size", got.size(), 2);
    end
    chk("b2b_err_cnt", err_cnt, 0);
    idle(10);

    // 5-clock glitch on an idle line
    base = done_cnt;
    serial_in = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    serial_in = 1'b1;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (busy) busy_cycles++;
    end
    chk("glitch_busy_bounded", {31'd0, (busy_cycles > 0) && (busy_cycles <= 12)}, 32'd1);
    chk("glitch_busy_end", {31'd0, busy}, 32'd0);
    chk("glitch_no_done", done_cnt, base);
    chk("glitch_no_err", err_cnt, 0);
    @(posedge clock); #1;

    // Stop bit low, break held, then a good frame
    base = done_cnt;
    send_frame(8'h3C, 20, 1'b0);
    serial_in = 1'b0;
    repeat (100) @(posedge clock);
    #1;
    idle(40);
    chk("ferr_err_cnt", err_cnt, 1);
    chk("ferr_no_done", done_cnt, base);
    chk("ferr_byte_held", {24'd0, out_Byte}, 32'hFF);
    send_frame(8'h11, 20, 1'b1);
    wait_done(base + 1);
    chk("ferr_next_done", done_cnt, base + 1);
    chk("ferr_next_byte", {24'd0, out_Byte}, 32'h11);
    chk("ferr_err_final", err_cnt, 1);
    idle(5);

    // Reset in the middle of data bit 4 of 0x5A
    base = done_cnt;
    b = 8'h5A;
    serial_in = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      serial_in = b[i];
      repeat (20) @(posedge clock);
      #1;
    end
    serial_in = b[4];
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_byte", {24'd0, out_Byte}, 32'h00);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, r_done}, 32'd0);
    chk("midrst_err", {31'd0, r_frame_err}, 32'd0);
    @(posedge clock); #1;
    idle(40);
    chk("midrst_no_pulse", done_cnt, base);
    send_frame(8'hC3, 20, 1'b1);
    wait_done(base + 1);
    chk("midrst_next_done", done_cnt, base + 1);
    chk("midrst_next_byte", {24'd0, out_Byte}, 32'hC3);
    idle(5);

    // Full-rate loopback of every byte value
    got.delete();
    base = done_cnt;
    ebase = err_cnt;
    for (int i = 0; i < 256; i++) send_frame(8'(i), 20, 1'b1);
    wait_done(base + 256);
    chk("loop_done_cnt", done_cnt - base, 256);
    chk("loop_err_cnt", err_cnt - ebase, 0);
    for (int i = 0; i < 256 && i < got.size(); i++) chk("loop_byte", {24'd0, got[i]}, i);
    idle(5);

    // Baud mismatch on the stimulus side, random bytes and idle gaps
    for (int k = 0; k < 2; k++) begin
      got.delete();
      exp_q.delete();
      base = done_cnt;
      ebase = err_cnt;
      for (int i = 0; i < 24; i++) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        send_frame(b, cpbs[k], 1'b1);
        idle($urandom_range(20, 40));
      end
      wait_done(base + 24);
      chk("drift_done_cnt", done_cnt - base, 24);
      chk("drift_err_cnt", err_cnt - ebase, 0);
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
        chk("drift_byte", {24'd0, got[i]}, {24'd0, exp_q[i]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
